// File: rtl/fcl_seq_pkg.sv
// FC1 loop sequencer shared types.
// State encoding and port width helper.
package fcl_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_st_e;

  // clog2 that never returns less than 1 bit
  function automatic int clog2m1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fcl_idx_cnt.sv
// FC1 index counter: clear, enable,
// terminal flag at MAX-1, wraps to 0.
module fcl_idx_cnt #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q,
  output logic         o_term
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_q;

  assign o_q    = r_q;
  assign o_term = (r_q == LAST);

  // clear wins over enable; wrap on terminal
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= o_term ? '0 : r_q + W'(1);
    end
  end

endmodule

// File: rtl/fcl_seq_ctrl.sv
// FC1 loop sequencer: neuron x feature walk,
// MAC strobes, result write, layer handshake.
module fcl_seq_ctrl
  import fcl_seq_pkg::*;
#(
  parameter int N_IN    = 400,
  parameter int N_OUT   = 120,
  parameter int MAC_LAT = 2
) (
  input  logic seq_clk,
  input  logic seq_rstn,
  input  logic seq_start,
  input  logic seq_en,
  output logic seq_busy,
  output logic seq_done,
  output logic [clog2m1(N_IN)-1:0]       in_addr,
  output logic [clog2m1(N_IN*N_OUT)-1:0] w_addr,
  output logic [clog2m1(N_OUT)-1:0]      out_addr,
  output logic mac_en,
  output logic mac_clr,
  output logic out_wr
);

  localparam int IW = clog2m1(N_IN);
  localparam int WW = clog2m1(N_IN * N_OUT);
  localparam int OW = clog2m1(N_OUT);
  localparam int DW = clog2m1(MAC_LAT);

  seq_st_e r_state;
  seq_st_e w_nxt;

  logic [WW-1:0] r_waddr;
  logic [DW-1:0] r_drn;

  logic w_start;
  logic w_beat;
  logic w_in_last;
  logic w_drn_zero;
  logic w_out_last;
  logic w_out_adv;

  assign w_start = seq_start &
    ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_beat     = (r_state == S_RUN) & seq_en;
  assign w_drn_zero = (r_state == S_DRAIN) &
    (r_drn == '0);
  assign w_out_adv  = w_drn_zero & ~w_out_last;

  fcl_idx_cnt #(.MAX(N_IN), .W(IW)) u_in_cnt (
    .i_clk  (seq_clk),
    .i_rstn (seq_rstn),
    .i_clr  (w_start),
    .i_en   (w_beat),
    .o_q    (in_addr),
    .o_term (w_in_last)
  );

  fcl_idx_cnt #(.MAX(N_OUT), .W(OW)) u_out_cnt (
    .i_clk  (seq_clk),
    .i_rstn (seq_rstn),
    .i_clr  (w_start),
    .i_en   (w_out_adv),
    .o_q    (out_addr),
    .o_term (w_out_last)
  );

  assign w_addr = r_waddr;

  // state register
  always_ff @(posedge seq_clk or negedge seq_rstn) begin
    if (!seq_rstn) r_state <= S_IDLE;
    else           r_state <= w_nxt;
  end

  // running weight index, cleared only by start
  always_ff @(posedge seq_clk or negedge seq_rstn) begin
    if (!seq_rstn)   r_waddr <= '0;
    else if (w_start) r_waddr <= '0;
    else if (w_beat)  r_waddr <= r_waddr + WW'(1);
  end

  // MAC drain countdown after a neuron's last beat
  always_ff @(posedge seq_clk or negedge seq_rstn) begin
    if (!seq_rstn) begin
      r_drn <= '0;
    end else if (w_beat & w_in_last) begin
      r_drn <= DW'(MAC_LAT - 1);
    end else if ((r_state == S_DRAIN) && (r_drn != '0)) begin
      r_drn <= r_drn - DW'(1);
    end
  end

  // next state and strobes
  always_comb begin
    w_nxt    = r_state;
    seq_busy = 1'b0;
    seq_done = 1'b0;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    out_wr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (seq_start) w_nxt = S_RUN;
      end
      S_RUN: begin
        seq_busy = 1'b1;
        mac_en   = seq_en;
        mac_clr  = seq_en & (in_addr == '0);
        if (w_beat & w_in_last) w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        seq_busy = 1'b1;
        out_wr   = w_drn_zero;
        if (w_drn_zero)
          w_nxt = w_out_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        seq_done = 1'b1;
        w_nxt    = seq_start ? S_RUN : S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fcl_seq_ctrl.sv
// FC1 sequencer bench: table-driven layer runs
// plus reset, abort and 1x1x1 boundary checks.
module tb_fcl_seq_ctrl;

  logic       clk;
  logic       rstn;
  logic       seq_start, seq_en;
  logic       seq_busy, seq_done;
  logic [1:0] in_addr;
  logic [3:0] w_addr;
  logic [1:0] out_addr;
  logic       mac_en, mac_clr, out_wr;

  logic       b_start, b_en;
  logic       b_busy, b_done;
  logic [0:0] b_in, b_w, b_o;
  logic       b_me, b_mc, b_wr;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic st, en;
    logic busy, done, me, mc, wr;
    int   ia, wa, oa;
  } vec_t;

  vec_t tab[$];

  fcl_seq_ctrl #(.N_IN(4), .N_OUT(3), .MAC_LAT(2)) dut (
    .seq_clk   (clk),
    .seq_rstn  (rstn),
    .seq_start (seq_start),
    .seq_en    (seq_en),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .out_addr  (out_addr),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .out_wr    (out_wr)
  );

  fcl_seq_ctrl #(.N_IN(1), .N_OUT(1), .MAC_LAT(1)) dut_b (
    .seq_clk   (clk),
    .seq_rstn  (rstn),
    .seq_start (b_start),
    .seq_en    (b_en),
    .seq_busy  (b_busy),
    .seq_done  (b_done),
    .in_addr   (b_in),
    .w_addr    (b_w),
    .out_addr  (b_o),
    .mac_en    (b_me),
    .mac_clr   (b_mc),
    .out_wr    (b_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic st, en, busy, done, me, mc, wr,
    input int ia, wa, oa);
    vec_t v;
    v.st = st; v.en = en; v.busy = busy;
    v.done = done; v.me = me; v.mc = mc;
    v.wr = wr; v.ia = ia; v.wa = wa; v.oa = oa;
    return v;
  endfunction

  // one layer of N_IN=4, N_OUT=3, MAC_LAT=2
  task automatic build(input int stall, mst,
                       input int lead, tail,
                       input int lwa, loa);
    tab.delete();
    if (lead != 0)
      tab.push_back(mk(1, 1, 0, 0, 0, 0, 0,
                       0, lwa, loa));
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (stall != 0 && n == 1 && i == 2)
          repeat (3)
            tab.push_back(mk(0, 0, 1, 0, 0, 0, 0,
                             2, 6, 1));
        tab.push_back(mk(
          (mst != 0 && i == 1), 1, 1, 0, 1,
          (i == 0), 0, i, 4 * n + i, n));
      end
      tab.push_back(mk(mst != 0, 1, 1, 0, 0, 0, 0,
                       0, 4 * n + 4, n));
      tab.push_back(mk(mst != 0, 1, 1, 0, 0, 0, 1,
                       0, 4 * n + 4, n));
    end
    tab.push_back(mk(tail != 0, 1, 0, 1, 0, 0, 0,
                     0, 12, 2));
  endtask

  task automatic apply_row(input vec_t v,
                           input string tg);
    seq_start = v.st;
    seq_en    = v.en;
    #1;
    chk({tg, ".busy"}, 32'(seq_busy), 32'(v.busy));
    chk({tg, ".done"}, 32'(seq_done), 32'(v.done));
    chk({tg, ".mac_en"}, 32'(mac_en), 32'(v.me));
    chk({tg, ".mac_clr"}, 32'(mac_clr), 32'(v.mc));
    chk({tg, ".out_wr"}, 32'(out_wr), 32'(v.wr));
    chk({tg, ".in_addr"}, 32'(in_addr), v.ia);
    chk({tg, ".w_addr"}, 32'(w_addr), v.wa);
    chk({tg, ".out_addr"}, 32'(out_addr), v.oa);
  endtask

  task automatic run_tab(input string nm,
                         input int exp_lat);
    int first = -1;
    int dn    = -1;
    for (int k = 0; k < tab.size(); k++) begin
      apply_row(tab[k], $sformatf("%s.r%0d", nm, k));
      if (first < 0 && seq_busy) first = k;
      if (dn < 0 && seq_done) dn = k;
      @(negedge clk);
    end
    chk({nm, ".done_lat"}, dn - first, exp_lat);
  endtask

  initial begin
    rstn = 1'b0;
    seq_start = 1'b0; seq_en = 1'b0;
    b_start = 1'b0; b_en = 1'b0;
    #2;
    apply_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              "reset");
    @(negedge clk);
    rstn = 1'b1;

    apply_row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
              "idle");
    @(negedge clk);

    build(0, 0, 1, 0, 0, 0);
    run_tab("clean", 18);
    apply_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 2),
              "post");
    @(negedge clk);

    build(1, 1, 1, 1, 12, 2);
    run_tab("stall", 21);

    build(0, 0, 0, 0, 0, 0);
    run_tab("b2b", 18);

    build(0, 0, 1, 0, 12, 2);
    for (int k = 0; k < 7; k++) begin
      apply_row(tab[k], $sformatf("abort.r%0d", k));
      if (k < 6) @(negedge clk);
    end
    rstn = 1'b0;
    #1;
    apply_row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0),
              "abort.rst");
    @(negedge clk);
    rstn = 1'b1;

    build(0, 0, 1, 0, 0, 0);
    run_tab("restart", 18);

    seq_start = 1'b0; seq_en = 1'b0;
    b_start = 1'b1; b_en = 1'b1;
    #1;
    chk("b.idle.busy", 32'(b_busy), 0);
    chk("b.idle.mac_en", 32'(b_me), 0);
    @(negedge clk);
    b_start = 1'b0;
    #1;
    chk("b.run.busy", 32'(b_busy), 1);
    chk("b.run.mac_en", 32'(b_me), 1);
    chk("b.run.mac_clr", 32'(b_mc), 1);
    chk("b.run.w_addr", 32'(b_w), 0);
    chk("b.run.out_wr", 32'(b_wr), 0);
    @(negedge clk);
    #1;
    chk("b.drn.out_wr", 32'(b_wr), 1);
    chk("b.drn.mac_en", 32'(b_me), 0);
    chk("b.drn.out_addr", 32'(b_o), 0);
    chk("b.drn.done", 32'(b_done), 0);
    @(negedge clk);
    #1;
    chk("b.done.done", 32'(b_done), 1);
    chk("b.done.busy", 32'(b_busy), 0);
    chk("b.done.out_wr", 32'(b_wr), 0);
    @(negedge clk);
    #1;
    chk("b.idle2.done", 32'(b_done), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
